vga_line_fetch: RTL and testbench

//  Upstream pixel-fetch stage for the VGA path; sits between the image memory and the RGB mux of the VGA top.

---
 rtl/vga_pkg.sv | 11 +
 rtl/vga_line_ram.sv | 33 +++
 rtl/vga_line_fetch.sv | 154 +++++++++++++++
 tb/tb_vga_line_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and the line-fetch FSM state type.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

endpackage

// File: rtl/vga_line_ram.sv
// vga_line_ram: ping-pong line buffer, one write port and one registered read port.
//  clk_i/rst_ni        clock, async active-low reset (clears the pixel register only)
//  we_i/waddr_i/wdata_i fill port, address is {buffer, column}
//  re_i/raddr_i        read enable (0 forces a black pixel) and {buffer, column}
//  pixel_o             registered grey pixel, one clock after the read address
module vga_line_ram #(
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    pixel_o
);

    logic [7:0] mem_q [2**AW];
    logic [7:0] pixel_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pixel_q <= '0;
        else         pixel_q <= re_i ? mem_q[raddr_i] : '0;
    end

    assign pixel_o = pixel_q;

endmodule

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: fetches the next display row during hblank and serves scaled grey pixels.
//  clk_i/rst_ni           clock, async active-low reset
//  x_i/y_i/video_on_i     raster position and active-video enable from the sync generator
//  mem_req_o/mem_addr_o   one read request per cycle while fetching
//  mem_rdata_i/mem_valid_i read data returning a fixed latency after each request
//  pixel_o                registered grey pixel for the current (x,y)
//  underrun_o             sticky: a line started before its row was fetched
module vga_line_fetch
    import vga_pkg::*;
#(
    parameter int          IMG_W   = 100,
    parameter int          IMG_H   = 100,
    parameter int          HSCALE  = 3,
    parameter int          VSCALE  = 1,
    parameter int          MEM_LAT = 2,
    parameter logic [31:0] BASE    = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic        video_on_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_valid_i,
    output logic [7:0]  pixel_o,
    output logic        underrun_o
);

    localparam int CW = $clog2(IMG_W + 1);
    // generous bound on requests in flight, including abandoned fetches
    localparam int OW = $clog2(IMG_W + MEM_LAT + 2 * (H_TOTAL - H_ACTIVE) + 1);

    fetch_state_t  state_q, state_d;
    logic [CW-1:0] col_q, col_d, wr_col_q, wr_col_d, rd_col;
    logic [OW-1:0] out_q, out_d, skip_q, skip_d;
    logic [31:0]   srow_q, srow_d, addr_q, addr_d, srow;
    logic [9:0]    x_q, yn;
    logic          req_q, req_d, sel_q, sel_d, under_q, under_d;
    logic          back_ready_q, back_ready_d, back_blank_q, back_blank_d;
    logic          front_blank_q, front_blank_d;
    logic          hb, ls, take, wr_en, fetch_ok, show;

    assign hb       = x_i == 10'(H_ACTIVE) && x_q != 10'(H_ACTIVE);
    assign ls       = x_i == '0 && x_q != '0;
    assign yn       = (y_i == 10'(V_TOTAL - 1)) ? '0 : y_i + 10'd1;
    assign srow     = 32'(yn) / 32'(VSCALE);
    assign fetch_ok = 32'(yn) < 32'(IMG_H * VSCALE);
    // valids with nothing outstanding belong to requests issued before reset
    assign take     = mem_valid_i && out_q != '0;
    assign out_d    = out_q + OW'(req_q) - OW'(take);

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        wr_col_d      = wr_col_q;
        srow_d        = srow_q;
        addr_d        = addr_q;
        req_d         = 1'b0;
        sel_d         = sel_q;
        back_ready_d  = back_ready_q;
        back_blank_d  = back_blank_q;
        front_blank_d = front_blank_q;
        under_d       = under_q;
        skip_d        = (take && skip_q != '0) ? skip_q - OW'(1) : skip_q;
        wr_en         = take && skip_q == '0 && state_q != IDLE;
        if (wr_en) wr_col_d = wr_col_q + CW'(1);
        if (state_q == FETCH) begin
            req_d   = 1'b1;
            addr_d  = BASE + srow_q * 32'(IMG_W) + 32'(col_q);
            col_d   = col_q + CW'(1);
            state_d = (col_q == CW'(IMG_W - 1)) ? DRAIN : FETCH;
        end
        if (state_q == DRAIN && wr_col_d == CW'(IMG_W) && out_d == '0) begin
            back_ready_d = 1'b1;
            state_d      = IDLE;
        end
        // a new hblank always wins: responses still in flight are discarded via skip
        if (hb) begin
            wr_en        = 1'b0;
            req_d        = 1'b0;
            skip_d       = out_d;
            col_d        = '0;
            wr_col_d     = '0;
            srow_d       = srow;
            back_ready_d = !fetch_ok;
            back_blank_d = !fetch_ok;
            state_d      = fetch_ok ? FETCH : IDLE;
        end
        // back_ready_d already includes a fill completing in this same cycle
        if (ls) begin
            sel_d         = back_ready_d ? ~sel_q : sel_q;
            front_blank_d = back_ready_d ? back_blank_q : 1'b1;
            under_d       = under_q || !back_ready_d;
            back_ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            col_q         <= '0;
            wr_col_q      <= '0;
            out_q         <= '0;
            skip_q        <= '0;
            srow_q        <= '0;
            addr_q        <= '0;
            req_q         <= 1'b0;
            x_q           <= '0;
            sel_q         <= 1'b0;
            back_ready_q  <= 1'b0;
            back_blank_q  <= 1'b0;
            front_blank_q <= 1'b1;
            under_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            wr_col_q      <= wr_col_d;
            out_q         <= out_d;
            skip_q        <= skip_d;
            srow_q        <= srow_d;
            addr_q        <= addr_d;
            req_q         <= req_d;
            x_q           <= x_i;
            sel_q         <= sel_d;
            back_ready_q  <= back_ready_d;
            back_blank_q  <= back_blank_d;
            front_blank_q <= front_blank_d;
            under_q       <= under_d;
        end
    end

    // read with next-cycle select/blank so the first pixel of a line sees the swap
    assign show   = video_on_i && 32'(x_i) < 32'(IMG_W * HSCALE) &&
                    32'(y_i) < 32'(IMG_H * VSCALE) && y_i < 10'(V_ACTIVE) && !front_blank_d;
    assign rd_col = show ? CW'(32'(x_i) / 32'(HSCALE)) : '0;

    vga_line_ram #(.AW(CW + 1)) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_en),
        .waddr_i ({~sel_q, wr_col_q}),
        .wdata_i (mem_rdata_i),
        .re_i    (show),
        .raddr_i ({sel_d, rd_col}),
        .pixel_o (pixel_o)
    );

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign underrun_o = under_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: line-level reference model with randomized video_on, rows and memory data.
module tb_vga_line_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        von = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic [7:0]  pixel;
    logic        underrun;

    always #10 clk = ~clk;

    vga_line_fetch dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .x_i         (x),
        .y_i         (y),
        .video_on_i  (von),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .mem_valid_i (mem_valid),
        .pixel_o     (pixel),
        .underrun_o  (underrun)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    int unsigned seed;
    int lat = 2;
    int pat_mode = 1;
    int cyc = 0;
    int          due_q[$];
    logic [31:0] adr_q[$];
    logic [31:0] reqs[$];

    function automatic logic [7:0] mem_byte(input int mode, input logic [31:0] a);
        return mode != 0 ? 8'(a % 100) : 8'(a * 37 + seed);
    endfunction

    // memory: answers each request exactly lat cycles later
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_req === 1'b1) begin
                due_q.push_back(cyc + lat);
                adr_q.push_back(mem_addr);
                reqs.push_back(mem_addr);
            end
            mem_valid = 1'b0;
            if (due_q.size() != 0 && due_q[0] <= cyc) begin
                mem_valid = 1'b1;
                mem_rdata = mem_byte(pat_mode, adr_q[0]);
                void'(due_q.pop_front());
                void'(adr_q.pop_front());
            end
        end
    end

    // reference model: which source row each buffer holds, at line granularity
    int front_row = -1, front_mode = 0;
    int pend_row = -1, pend_mode = 0;
    bit pend = 0, pend_fits = 0, exp_under = 0;
    int prev_x = 0;
    int fetch_row = -2;

    task automatic line_start();
        if (pend && pend_fits) begin
            front_row  = pend_row;
            front_mode = pend_mode;
            pend       = 0;
        end else begin
            exp_under = 1;
            front_row = -1;
        end
    endtask

    task automatic hblank(input int yv);
        int yn;
        yn = (yv == 524) ? 0 : yv + 1;
        pend = 1;
        pend_mode = pat_mode;
        pend_row = (yn < 100) ? yn : -1;
        pend_fits = (yn >= 100) || (lat + 100 + 8 <= 320);
        fetch_row = pend_row;
        reqs.delete();
    endtask

    task automatic model_reset();
        front_row = -1;
        pend = 0;
        exp_under = 0;
        prev_x = 0;
        fetch_row = -2;
        reqs.delete();
    endtask

    // holds (x,y) for two clocks, then compares the pixel for that position
    task automatic step(input int xv, input int yv, input bit vo);
        int e;
        x = 10'(xv);
        y = 10'(yv);
        von = vo;
        if (xv == 0 && prev_x != 0) line_start();
        if (xv == 640 && prev_x != 640) hblank(yv);
        prev_x = xv;
        e = (vo && xv < 300 && yv < 100 && front_row >= 0) ? int'(mem_byte(front_mode, front_row * 100 + xv / 3)) : 0;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("pixel x=%0d y=%0d", xv, yv), pixel, e);
    endtask

    task automatic run_line(input int yv, input int xstop);
        for (int xv = 0; xv <= xstop; xv++)
            step(xv, yv, xv < 640 && yv < 480 && $urandom_range(0, 7) != 0);
        if (xstop == 799) begin
            if (fetch_row >= 0) begin
                check($sformatf("req count y=%0d", yv), reqs.size(), 100);
                for (int i = 0; i < reqs.size() && i < 100; i++)
                    check($sformatf("req addr y=%0d i=%0d", yv, i), reqs[i], fetch_row * 100 + i);
            end else if (fetch_row == -1) begin
                check($sformatf("no req y=%0d", yv), reqs.size(), 0);
            end
            fetch_row = -2;
            check($sformatf("underrun y=%0d", yv), underrun, exp_under);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pixel"}, pixel, 0);
        check({tag, " mem_req"}, mem_req, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " underrun"}, underrun, 0);
    endtask

    initial begin
        int ry;
        seed = $urandom;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        // column-index memory: row 4 fetched at 500..599, line 5 shows x/3
        pat_mode = 1;
        run_line(3, 799);
        run_line(4, 799);
        pat_mode = 0;
        run_line(5, 799);
        // bottom of the image: no fetch for row 100, line 100 black
        run_line(98, 799);
        run_line(99, 799);
        run_line(100, 799);
        run_line(101, 799);
        // frame wrap fetches row 0
        run_line(523, 799);
        run_line(524, 799);
        run_line(0, 799);
        run_line(1, 799);
        // random row pairs
        for (int k = 0; k < 2; k++) begin
            ry = $urandom_range(0, 110);
            run_line(ry, 799);
            run_line(ry + 1, 799);
        end
        // reset in the middle of a fetch, then a clean refetch
        run_line(9, 799);
        run_line(10, 666);
        rst_n = 1'b0;
        x = '0;
        #1;
        check_reset_outputs("mid-fetch reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_line(10, 799);
        run_line(11, 799);
        run_line(19, 799);
        // memory far slower than blanking: sticky underrun, black lines
        lat = 400;
        run_line(20, 799);
        run_line(21, 799);
        run_line(22, 799);
        rst_n = 1'b0;
        #1;
        check("underrun cleared by reset", underrun, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
